// File: rtl/task3_multiplier.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per clock.
// Optional macro TASK3_ZERO_SKIP_EN ends the operation once no set multiplier bits remain.
module task3_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               last_iter;

  function automatic logic [2*WIDTH-1:0] partial_product(
    input logic [2*WIDTH-1:0] m,
    input logic               bit0,
    input logic [CNT_W-1:0]   sh
  );
    return bit0 ? (m << sh) : '0;
  endfunction

  always_comb begin
    acc_next = acc + partial_product(mcand, mplier[0], cnt);
`ifdef TASK3_ZERO_SKIP_EN
    // Stop as soon as the bits still to be shifted in are all zero.
    last_iter = (int'(cnt) == WIDTH - 1) || ((mplier >> 1) == '0);
`else
    last_iter = (int'(cnt) == WIDTH - 1);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      P      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= BUSY;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last_iter) begin
            P     <= acc_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_task3_multiplier.sv
// Directed, table-driven bench for task3_multiplier (default or TASK3_ZERO_SKIP_EN build).
module tb_task3_multiplier;

  localparam int WIDTH = 4;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] P;
  logic               busy;
  logic               done;

  int errors = 0;
  int checks = 0;

  task3_multiplier #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .P(P), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] p;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [WIDTH-1:0] b);
`ifdef TASK3_ZERO_SKIP_EN
    int h;
    h = -1;
    for (int i = 0; i < WIDTH; i++) if (b[i]) h = i;
    return (h < 0) ? 1 : h + 1;
`else
    return WIDTH;
`endif
  endfunction

  // Called right after the start edge has been taken; returns edges until done.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 20);
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  vec_t vecs[8];
  int   lat;
  int   pulses;

  initial begin
    vecs[0] = '{4'd15, 4'd12, 8'd180};
    vecs[1] = '{4'd10, 4'd8,  8'd80};
    vecs[2] = '{4'd12, 4'd5,  8'd60};
    vecs[3] = '{4'd2,  4'd4,  8'd8};
    vecs[4] = '{4'd0,  4'd13, 8'd0};
    vecs[5] = '{4'd15, 4'd15, 8'd225};
    vecs[6] = '{4'd1,  4'd1,  8'd1};
    vecs[7] = '{4'd5,  4'd0,  8'd0};

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    check("reset_P", int'(P), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Each subsequent start is issued in the previous done cycle.
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b);
      check($sformatf("busy_after_start[%0d]", i), int'(busy), 1);
      A = ~vecs[i].a; B = ~vecs[i].b;
      wait_done(lat);
      check($sformatf("latency[%0d]", i), lat, exp_lat(vecs[i].b));
      check($sformatf("P[%0d]", i), int'(P), int'(vecs[i].p));
      check($sformatf("busy_in_done[%0d]", i), int'(busy), 0);
    end
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("P_holds", int'(P), 0);
    A = 4'd15; B = 4'd15;
    repeat (3) @(negedge clk);
    check("P_holds_idle", int'(P), 0);

    // Start while busy must be ignored.
    issue(4'd7, 4'd3);
    A = 4'd9; B = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("busy_start_pulses", pulses, 1);
    check("busy_start_P", int'(P), 21);

    // Asynchronous abort mid-operation.
    issue(4'd15, 4'd15);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_P", int'(P), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    check("abort_P_after", int'(P), 0);
    issue(4'd3, 4'd6);
    wait_done(lat);
    check("post_abort_latency", lat, exp_lat(4'd6));
    check("post_abort_P", int'(P), 18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
